cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result-bus (common data bus) arbiter for the out-of-order core. Collects finished results from up to `UNITS` execution units, grants one per cycle with round-robin fairness, and broadcasts the winner's reservation-station ID and value on a registered bus. Every reservation station's operand-update port, and the register-file tag logic, are fed from this bus. The broadcast ID matches the ID the reservation station reported on dispatch.

## Interface
- `UNITS`, 4: number of result-producing units; must be ≥ 2.
- `OPERAND_WIDTH`, 32: result value width.
- `RS_ID_WIDTH`, 5: system-wide reservation-station ID width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk` (synchronised at top level).
- `flush` in 1: synchronous pipeline flush (mispredict); active-high.
- `result_valid[0:UNITS-1]` in 1 each: unit i presents a result.
- `result_ready[0:UNITS-1]` out 1 each: unit i's result is taken this cycle.
- `result_rs_id[0:UNITS-1]` in RS_ID_WIDTH each: producing reservation-station ID.
- `result_value[0:UNITS-1]` in OPERAND_WIDTH each: result value.
- `cdb_valid` out 1: broadcast valid; drives all `operand_valid` inputs.
- `cdb_rs_id` out RS_ID_WIDTH: broadcast tag.
- `cdb_value` out OPERAND_WIDTH: broadcast value.
- `grant_unit` out $clog2(UNITS): index of the unit that produced the current broadcast (debug and performance counters).

## Operation
- State: round-robin pointer `rr_ptr` (0..UNITS-1) and output register {`cdb_valid`, `cdb_rs_id`, `cdb_value`, `grant_unit`}.
- Arbitration (combinational):
  - Scan units in order `rr_ptr`, `rr_ptr+1`, …, wrapping modulo UNITS.
  - The first unit with `result_valid` wins. At most one `result_ready` is high per cycle.
  - `result_ready[i]` is high only when i wins and `flush` is low.
  - `result_ready` never depends on `result_ready` itself. It may depend combinationally on `result_valid`; units must not make `result_valid` depend on `result_ready`.
- Handshake: the transfer for unit i occurs on a cycle where `result_valid[i] && result_ready[i]`. Units hold valid, ID and value stable until the transfer.
- On transfer of unit k:
  - The output register loads k's ID and value, `cdb_valid`←1, `grant_unit`←k.
  - `rr_ptr`←(k+1) mod UNITS. The wrap from UNITS-1 goes to 0.
- No transfer (no valid or flush): `cdb_valid`←0. `cdb_rs_id`, `cdb_value` and `grant_unit` hold their previous values. `rr_ptr` holds.
- The bus has no backpressure: every registered broadcast is consumed in its one valid cycle.
- Fairness: a continuously valid unit is granted within UNITS cycles of first asserting valid.
- `flush`:
  - Forces all `result_ready` low and `cdb_valid`←0 on the next edge.
  - Does not change `rr_ptr`.
  - A broadcast already registered at the flush cycle is still visible that cycle; consumers qualify it themselves.
- Reset (asynchronous, `rst`=0): `rr_ptr`=0, `cdb_valid`=0, `cdb_rs_id`=0, `cdb_value`=0, `grant_unit`=0. All `result_ready`=0 while reset is asserted. Reset mid-burst discards any in-flight broadcast.

## Timing
- Arbitration latency is zero: `result_ready` is combinational in the same cycle as `result_valid`.
- Broadcast latency is one cycle: the transfer at edge N is visible on `cdb_*` from edge N until edge N+1.
- Throughput: one result per cycle when any unit is valid. Back-to-back grants to the same unit are allowed only when no other unit is valid.
- Simultaneous arrival: unit order is decided solely by `rr_ptr`.
- A unit dropping valid without a transfer is an illegal protocol violation. The arbiter behaves as if that unit was never valid that cycle.
- Reservation stations observe `cdb_*` one cycle after the transfer. An entry allocated in the same cycle as a broadcast must capture the broadcast; this is the station's responsibility, not the arbiter's.

## Test plan
- Reset, then all `result_valid`=0 for 5 cycles -> `cdb_valid`=0, all `result_ready`=0, `rr_ptr`=0. Assert `rst`=0 mid-cycle -> outputs clear without waiting for a clock edge.
- Single request: unit 2 presents ID 5'd9, value 32'hDEADBEEF -> `result_ready[2]`=1 that cycle. Next cycle `cdb_valid`=1, `cdb_rs_id`=9, `cdb_value`=DEADBEEF, `grant_unit`=2. Cycle after, `cdb_valid`=0.
- All four units valid continuously from reset -> grant order 0,1,2,3,0,1 on consecutive cycles. `cdb_valid` stays high for the whole burst with no bubble.
- Wrap-around: grant unit 3, then only units 0 and 3 valid -> unit 0 wins (`rr_ptr`=0), then unit 3. Check no unit waits more than 4 cycles.
- Flush: units 1 and 2 valid, assert `flush` for one cycle -> both `result_ready`=0, `cdb_valid`=0 next cycle, `rr_ptr` unchanged. On release, unit 1 is granted first (given `rr_ptr`=1).
- Randomised valid patterns over 10k cycles with a scoreboard -> every accepted result is broadcast exactly once, in acceptance order. The max wait of any continuously valid unit is ≤ UNITS cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin result-bus arbiter; registered broadcast of the winning
//            unit's reservation-station ID and value.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int UNITS         = 4,
  parameter int OPERAND_WIDTH = 32,
  parameter int RS_ID_WIDTH   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [UNITS-1:0]           result_valid,
  output logic [UNITS-1:0]           result_ready,
  input  logic [RS_ID_WIDTH-1:0]     result_rs_id [UNITS],
  input  logic [OPERAND_WIDTH-1:0]   result_value [UNITS],
  output logic                       cdb_valid,
  output logic [RS_ID_WIDTH-1:0]     cdb_rs_id,
  output logic [OPERAND_WIDTH-1:0]   cdb_value,
  output logic [$clog2(UNITS)-1:0]   grant_unit
);

  localparam int c_PTR_W = $clog2(UNITS);

  logic [c_PTR_W-1:0]       r_rr_ptr;
  logic                     r_cdb_valid;
  logic [RS_ID_WIDTH-1:0]   r_cdb_rs_id;
  logic [OPERAND_WIDTH-1:0] r_cdb_value;
  logic [c_PTR_W-1:0]       r_grant_unit;

  logic                     w_win_any;
  logic [c_PTR_W-1:0]       w_win_idx;
  logic                     w_xfer;
  logic [c_PTR_W-1:0]       w_ptr_next;

  // Scan from the round-robin pointer upward, wrapping; the first valid unit wins.
  always_comb begin
    int w_scan;
    w_win_any = 1'b0;
    w_win_idx = '0;
    w_scan    = 0;
    for (int off = 0; off < UNITS; off++) begin
      w_scan = int'(r_rr_ptr) + off;
      if (w_scan >= UNITS) w_scan = w_scan - UNITS;
      if (!w_win_any && result_valid[w_scan]) begin
        w_win_any = 1'b1;
        w_win_idx = c_PTR_W'(w_scan);
      end
    end
  end

  assign w_xfer     = w_win_any & ~flush;
  assign w_ptr_next = (w_win_idx == c_PTR_W'(UNITS - 1)) ? '0 : w_win_idx + c_PTR_W'(1);

  // Reset gates ready directly so no unit believes it transferred while held in reset.
  always_comb begin
    result_ready = '0;
    if (w_xfer && rst) result_ready[w_win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_rs_id  <= '0;
      r_cdb_value  <= '0;
      r_grant_unit <= '0;
    end else begin
      r_cdb_valid <= w_xfer;
      if (w_xfer) begin
        r_cdb_rs_id  <= result_rs_id[w_win_idx];
        r_cdb_value  <= result_value[w_win_idx];
        r_grant_unit <= w_win_idx;
        r_rr_ptr     <= w_ptr_next;
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_rs_id  = r_cdb_rs_id;
  assign cdb_value  = r_cdb_value;
  assign grant_unit = r_grant_unit;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  localparam int UNITS = 4;
  localparam int OW    = 32;
  localparam int IW    = 5;
  localparam int PW    = $clog2(UNITS);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [UNITS-1:0] result_valid = '0;
  logic [UNITS-1:0] result_ready;
  logic [IW-1:0]    result_rs_id [UNITS];
  logic [OW-1:0]    result_value [UNITS];
  logic             cdb_valid;
  logic [IW-1:0]    cdb_rs_id;
  logic [OW-1:0]    cdb_value;
  logic [PW-1:0]    grant_unit;

  cdb_arbiter #(.UNITS(UNITS), .OPERAND_WIDTH(OW), .RS_ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_rs_id(result_rs_id), .result_value(result_value),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_value(cdb_value),
    .grant_unit(grant_unit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ecyc;
    int           unit;
    logic [IW-1:0] id;
    logic [OW-1:0] val;
  } item_t;

  item_t         q[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            auto_refill = 1'b0;
  int            ptr = 0;                 // reference round-robin pointer
  bit            pend [UNITS];
  logic [IW-1:0] pid  [UNITS];
  logic [OW-1:0] pval [UNITS];
  int            wt   [UNITS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    pid[i]  = IW'($urandom);
    pval[i] = $urandom;
  endtask

  task automatic clear_units();
    for (int i = 0; i < UNITS; i++) begin
      pend[i] = 1'b0;
      wt[i]   = 0;
    end
  endtask

  // One clock of stimulus; exp_w: -2 don't care, -1 no grant, else directed winner.
  task automatic step(input bit f, input int exp_w);
    int w;
    int u;
    logic [UNITS-1:0] expr;
    @(posedge clk); #1;
    flush = f;
    for (int i = 0; i < UNITS; i++) begin
      result_valid[i] = pend[i];
      result_rs_id[i] = pid[i];
      result_value[i] = pval[i];
    end
    #3;
    w = -1;
    if (!f) begin
      for (int k = 0; k < UNITS; k++) begin
        u = (ptr + k) % UNITS;
        if (w < 0 && pend[u]) w = u;
      end
    end
    expr = '0;
    if (w >= 0) expr[w] = 1'b1;
    chk("ready_model", 64'(result_ready), 64'(expr));
    if (exp_w != -2) begin
      expr = '0;
      if (exp_w >= 0) expr[exp_w] = 1'b1;
      chk("ready_directed", 64'(result_ready), 64'(expr));
    end
    if (!f) begin
      for (int i = 0; i < UNITS; i++) begin
        if (pend[i]) begin
          wt[i]++;
          if (result_ready[i]) begin
            chk("fair_wait_le_units", 64'(wt[i] <= UNITS), 64'd1);
            wt[i] = 0;
          end
        end
      end
    end
    if (w >= 0) begin
      q.push_back('{cyc + 1, w, pid[w], pval[w]});
      ptr     = (w + 1) % UNITS;
      pend[w] = 1'b0;
      if (auto_refill) new_req(w);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
    chk({tag, "_cdb_rs_id"}, 64'(cdb_rs_id), 64'd0);
    chk({tag, "_cdb_value"}, 64'(cdb_value), 64'd0);
    chk({tag, "_grant_unit"}, 64'(grant_unit), 64'd0);
    chk({tag, "_ready"}, 64'(result_ready), 64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, released after one more edge.
  task automatic reset_mid();
    @(posedge clk); #2;
    rst    = 1'b0;
    mon_en = 1'b0;
    #1;
    check_cleared("async_rst");
    q.delete();
    ptr = 0;
    clear_units();
    result_valid = '0;
    flush = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: every broadcast must match the oldest accepted result, on the right cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cdb_valid) begin
        if (q.size() == 0) begin
          chk("bcast_spurious", 64'd1, 64'd0);
        end else begin
          item_t it;
          it = q.pop_front();
          chk("bcast_cycle", 64'(cyc), 64'(it.ecyc));
          chk("bcast_unit", 64'(grant_unit), 64'(it.unit));
          chk("bcast_id", 64'(cdb_rs_id), 64'(it.id));
          chk("bcast_value", 64'(cdb_value), 64'(it.val));
        end
      end else begin
        tests++;
        if (q.size() > 0 && q[0].ecyc <= cyc) begin
          fails++;
          $display("FAIL bcast_missing: cdb_valid 0 expected 1 unit %0d (t=%0t)", q[0].unit, $time);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < UNITS; i++) begin
      result_rs_id[i] = '0;
      result_value[i] = '0;
      pid[i] = '0;
      pval[i] = '0;
    end
    clear_units();
    #2 rst = 1'b0;
    #1 check_cleared("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    // Idle after reset
    repeat (5) step(1'b0, -1);
    chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);

    // Single request from unit 2
    pend[2] = 1'b1; pid[2] = 5'd9; pval[2] = 32'hDEADBEEF;
    step(1'b0, 2);
    step(1'b0, -1);
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_id", 64'(cdb_rs_id), 64'd9);
    chk("single_value", 64'(cdb_value), 64'hDEADBEEF);
    chk("single_unit", 64'(grant_unit), 64'd2);
    step(1'b0, -1);
    chk("single_drop", 64'(cdb_valid), 64'd0);

    // All units continuously valid from reset: 0,1,2,3,0,1 with no bubbles
    reset_mid();
    for (int i = 0; i < UNITS; i++) new_req(i);
    auto_refill = 1'b1;
    step(1'b0, 0); step(1'b0, 1); step(1'b0, 2);
    step(1'b0, 3); step(1'b0, 0); step(1'b0, 1);
    auto_refill = 1'b0;
    clear_units();
    step(1'b0, -1);
    chk("burst_last_valid", 64'(cdb_valid), 64'd1);

    // Wrap-around: grant 3, then 0 and 3 valid -> 0 then 3
    pend[3] = 1'b1; pid[3] = 5'd3; pval[3] = 32'h33;
    step(1'b0, 3);
    new_req(0); new_req(3);
    step(1'b0, 0);
    step(1'b0, 3);

    // Flush with units 1,2 valid and pointer at 1
    new_req(0);
    step(1'b0, 0);
    new_req(1); new_req(2);
    step(1'b1, -1);
    step(1'b0, 1);
    chk("flush_no_bcast", 64'(cdb_valid), 64'd0);
    step(1'b0, 2);

    // Reset in the middle of a burst discards the in-flight broadcast
    for (int i = 0; i < UNITS; i++) new_req(i);
    step(1'b0, -2);
    reset_mid();
    new_req(3); new_req(1);
    step(1'b0, 1);
    step(1'b0, 3);

    // Randomised traffic with occasional flushes
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < UNITS; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      step($urandom_range(0, 19) == 0, -2);
    end
    clear_units();
    repeat (3) step(1'b0, -1);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
